adj_row_fetch: RTL and testbench
================================

// Module: adj_row_fetch
// PURPOSE
//  Upstream request generator for the matrix cache pipeline. Takes one command (problem, row i, nverts),
//  streams j=0..nverts-1 lookups into the cache pipeline, and collects in-order isconn replies into an
//  adjacency row mask plus degree count. Hands the finished row downstream with valid/ready handshake.
//  Invalidates the cache when the problem number changes.
// PARAMETERS
//  VERTS_BITS  6  width of vertex indices; row mask width MAX_V = 2**VERTS_BITS
//  PROB_BITS   4  width of problem number
// PORTS
//  i_clk300         in   1           clock; all logic on rising edge
//  i_reset_n        in   1           synchronous reset, active low
//  i_cmd_valid      in   1           command present
//  o_cmd_ready      out  1           high only in IDLE; command taken when valid&ready
//  i_cmd_prob       in   PROB_BITS   problem number
//  i_cmd_i          in   VERTS_BITS  row index
//  i_cmd_nverts     in   VERTS_BITS  vertex count (0 allowed)
//  i_abort          in   1           cancel current row
//  o_matrix_req     out  1           lookup request to cache pipeline
//  o_matrix_prob    out  PROB_BITS   held stable from cmd accept until return to IDLE
//  o_matrix_i       out  VERTS_BITS  registered row index
//  o_matrix_j       out  VERTS_BITS  column index of current request
//  o_matrix_nverts  out  VERTS_BITS  registered nverts
//  o_matrix_squash  out  1           kills all in-flight lookups in cache pipeline
//  o_cache_clear    out  1           cache valid-bit clear request
//  i_matrix_valid   in   1           reply valid (in request order)
//  i_matrix_isconn  in   1           reply data
//  i_matrix_stalled in   1           cache not accepting this cycle
//  o_row_valid      out  1           row result available
//  i_row_ready      in   1           downstream accepts row
//  o_row_mask       out  MAX_V       bit j = isconn(i,j); bits >= nverts are 0
//  o_row_degree     out  VERTS_BITS+1 popcount of o_row_mask
// BEHAVIOUR
//  Reset (i_reset_n=0 at edge): state IDLE; all outputs 0 except o_cmd_ready=1; prob_known=0.
//  States: IDLE, CLEAR, ISSUE, DRAIN, DONE.
//  IDLE: on cmd accept register prob/i/nverts; zero mask, degree, req_j, resp_cnt.
//   -> CLEAR if !prob_known or i_cmd_prob != last_prob; else ISSUE (or DONE if nverts==0).
//  CLEAR: o_cache_clear=1 until a cycle with i_matrix_stalled=0; that cycle set last_prob, prob_known=1;
//   -> ISSUE (DONE if nverts==0).
//  ISSUE: o_matrix_req=1, o_matrix_j=req_j. Request accepted iff o_matrix_req & !i_matrix_stalled;
//   on accept req_j++; after accepting j=nverts-1 -> DRAIN. Stalled cycle: req and j held unchanged.
//  Replies: each i_matrix_valid writes mask[resp_cnt]<=isconn, degree+=isconn, resp_cnt++.
//   Accepted in ISSUE and DRAIN (replies may arrive while still issuing).
//  DRAIN: o_matrix_req=0; -> DONE in cycle after resp_cnt reaches nverts.
//  DONE: o_row_valid=1, mask/degree stable; on i_row_ready -> IDLE.
//  Abort: i_abort in CLEAR/ISSUE/DRAIN: o_matrix_squash=1 that cycle (combinational), o_matrix_req=0,
//   reply ignored, -> IDLE; no row produced. i_abort in IDLE/DONE ignored. CLEAR aborted before clear
//   accepted leaves prob_known unchanged.
//  Squash is asserted only on abort; replies never exceed nverts per command.
//  Widths: req_j, resp_cnt are VERTS_BITS+1 so nverts=MAX_V-1 completes without wrap; degree never
//   exceeds nverts.
//  Reset mid-row: immediate return to IDLE, prob_known=0 (next command always clears cache).
// TESTING
//  Reset, cmd prob=3,i=5,nverts=8, cache model row 0xA5 -> one clear cycle, 8 reqs j=0..7, mask=0x00A5, degree=4.
//  Same prob, stalled high cycles 2-4 of ISSUE -> j holds, no dup/skip, mask/degree identical, no clear.
//  nverts=0 -> no req, o_row_valid next state cycle, mask=0, degree=0; new prob still clears.
//  i_abort after 3 accepted reqs -> squash 1 cycle, IDLE, no o_row_valid; next cmd yields correct row.
//  i_row_ready low 10 cycles in DONE -> mask/degree stable, o_cmd_ready=0 throughout.
//  nverts=63 all-ones row -> degree=63, bit 63 = 0, counters do not wrap.

Source files
------------

// File: rtl/adj_row_fetch.sv
// Adjacency row fetcher: issues j=0..nverts-1 lookups into the matrix cache pipeline and
// assembles the in-order isconn replies into a row mask plus degree for downstream.
module adj_row_fetch #(
    parameter int unsigned VERTS_BITS = 6,
    parameter int unsigned PROB_BITS  = 4
) (
    input  logic                          i_clk300,
    input  logic                          i_reset_n,
    input  logic                          i_cmd_valid,
    output logic                          o_cmd_ready,
    input  logic [PROB_BITS-1:0]          i_cmd_prob,
    input  logic [VERTS_BITS-1:0]         i_cmd_i,
    input  logic [VERTS_BITS-1:0]         i_cmd_nverts,
    input  logic                          i_abort,
    output logic                          o_matrix_req,
    output logic [PROB_BITS-1:0]          o_matrix_prob,
    output logic [VERTS_BITS-1:0]         o_matrix_i,
    output logic [VERTS_BITS-1:0]         o_matrix_j,
    output logic [VERTS_BITS-1:0]         o_matrix_nverts,
    output logic                          o_matrix_squash,
    output logic                          o_cache_clear,
    input  logic                          i_matrix_valid,
    input  logic                          i_matrix_isconn,
    input  logic                          i_matrix_stalled,
    output logic                          o_row_valid,
    input  logic                          i_row_ready,
    output logic [(2**VERTS_BITS)-1:0]    o_row_mask,
    output logic [VERTS_BITS:0]           o_row_degree
);

    localparam int unsigned MAX_V = 2 ** VERTS_BITS;
    localparam int unsigned CW    = VERTS_BITS + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]            state;
    logic [2:0]            state_nxt;
    logic                  prob_known;
    logic [PROB_BITS-1:0]  last_prob;
    logic [PROB_BITS-1:0]  prob_q;
    logic [VERTS_BITS-1:0] i_q;
    logic [VERTS_BITS-1:0] nverts_q;
    logic [CW-1:0]         nverts_ext;
    logic [CW-1:0]         req_j;
    logic [CW-1:0]         resp_cnt;
    logic [MAX_V-1:0]      mask;
    logic [CW-1:0]         degree;

    logic abort_act;
    logic busy;
    logic req_acc;
    logic clear_acc;
    logic reply_acc;
    logic last_req;
    logic cmd_acc;
    logic new_prob;

    assign nverts_ext = {1'b0, nverts_q};

    // State register
    always_ff @(posedge i_clk300) begin
        if (!i_reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake decode; abort overrides pipeline-facing strobes in the same cycle
    always_comb begin
        state_nxt       = state;
        busy            = (state == S_CLEAR) || (state == S_ISSUE) || (state == S_DRAIN);
        abort_act       = i_abort && busy;
        o_matrix_req    = (state == S_ISSUE) && !i_abort;
        o_cache_clear   = (state == S_CLEAR) && !i_abort;
        o_matrix_squash = abort_act;
        req_acc         = o_matrix_req && !i_matrix_stalled;
        clear_acc       = o_cache_clear && !i_matrix_stalled;
        reply_acc       = i_matrix_valid && !i_abort && (resp_cnt < nverts_ext)
                          && ((state == S_ISSUE) || (state == S_DRAIN));
        last_req        = (req_j + CW'(1)) == nverts_ext;
        cmd_acc         = (state == S_IDLE) && i_cmd_valid;
        new_prob        = !prob_known || (i_cmd_prob != last_prob);

        case (state)
            S_IDLE: begin
                if (cmd_acc) begin
                    if (new_prob) begin
                        state_nxt = S_CLEAR;
                    end else if (i_cmd_nverts == '0) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_CLEAR: begin
                if (abort_act) begin
                    state_nxt = S_IDLE;
                end else if (clear_acc) begin
                    state_nxt = (nverts_q == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (abort_act) begin
                    state_nxt = S_IDLE;
                end else if (req_acc && last_req) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort_act) begin
                    state_nxt = S_IDLE;
                end else if (resp_cnt == nverts_ext) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (i_row_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Command registers, request/reply counters and row accumulation
    always_ff @(posedge i_clk300) begin
        if (!i_reset_n) begin
            prob_known <= 1'b0;
            last_prob  <= '0;
            prob_q     <= '0;
            i_q        <= '0;
            nverts_q   <= '0;
            req_j      <= '0;
            resp_cnt   <= '0;
            mask       <= '0;
            degree     <= '0;
        end else begin
            if (cmd_acc) begin
                prob_q   <= i_cmd_prob;
                i_q      <= i_cmd_i;
                nverts_q <= i_cmd_nverts;
                req_j    <= '0;
                resp_cnt <= '0;
                mask     <= '0;
                degree   <= '0;
            end
            if (clear_acc) begin
                last_prob  <= prob_q;
                prob_known <= 1'b1;
            end
            if (req_acc) begin
                req_j <= req_j + CW'(1);
            end
            if (reply_acc) begin
                mask[resp_cnt[VERTS_BITS-1:0]] <= i_matrix_isconn;
                degree                         <= degree + CW'(i_matrix_isconn);
                resp_cnt                       <= resp_cnt + CW'(1);
            end
        end
    end

    assign o_cmd_ready     = (state == S_IDLE);
    assign o_row_valid     = (state == S_DONE);
    assign o_matrix_prob   = prob_q;
    assign o_matrix_i      = i_q;
    assign o_matrix_j      = req_j[VERTS_BITS-1:0];
    assign o_matrix_nverts = nverts_q;
    assign o_row_mask      = mask;
    assign o_row_degree    = degree;

endmodule

// File: tb/tb_adj_row_fetch.sv
// Directed bench for adj_row_fetch with a two-stage in-order cache pipeline model.
module tb_adj_row_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_prob;
    logic [5:0]  cmd_i;
    logic [5:0]  cmd_nverts;
    logic        abort;
    logic        req;
    logic [3:0]  m_prob;
    logic [5:0]  m_i;
    logic [5:0]  m_j;
    logic [5:0]  m_nverts;
    logic        squash;
    logic        clear;
    logic        m_valid;
    logic        m_isconn;
    logic        stalled;
    logic        row_valid;
    logic        row_ready;
    logic [63:0] mask;
    logic [6:0]  degree;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adj_row_fetch dut (
        .i_clk300        (clk),
        .i_reset_n       (rst_n),
        .i_cmd_valid     (cmd_valid),
        .o_cmd_ready     (cmd_ready),
        .i_cmd_prob      (cmd_prob),
        .i_cmd_i         (cmd_i),
        .i_cmd_nverts    (cmd_nverts),
        .i_abort         (abort),
        .o_matrix_req    (req),
        .o_matrix_prob   (m_prob),
        .o_matrix_i      (m_i),
        .o_matrix_j      (m_j),
        .o_matrix_nverts (m_nverts),
        .o_matrix_squash (squash),
        .o_cache_clear   (clear),
        .i_matrix_valid  (m_valid),
        .i_matrix_isconn (m_isconn),
        .i_matrix_stalled(stalled),
        .o_row_valid     (row_valid),
        .i_row_ready     (row_ready),
        .o_row_mask      (mask),
        .o_row_degree    (degree)
    );

    // Cache pipeline model: replies two cycles after each accepted request, flushed by squash
    logic [1:0]  pv;
    logic [1:0]  pd;
    logic [63:0] row_bits = '0;
    int          acc_js[$];
    int          req_cyc = 0;
    int          stall_cyc = 0;
    int          clear_cyc = 0;
    int          clear_acc_n = 0;
    int          squash_cyc = 0;
    logic        stall_win = 1'b0;
    int          base_req = 0;
    int          clr_stall_n = 0;
    int          base_clr = 0;

    assign m_valid  = pv[1];
    assign m_isconn = pd[1];
    assign stalled  = (stall_win && req && (req_cyc - base_req) >= 1 && (req_cyc - base_req) <= 3)
                      || (clear && (clear_cyc - base_clr) < clr_stall_n);

    always @(posedge clk) begin
        if (!rst_n || squash) begin
            pv <= '0;
            pd <= '0;
        end else begin
            pv <= {pv[0], req & ~stalled};
            pd <= {pd[0], row_bits[m_j]};
        end
        if (rst_n) begin
            if (req && !stalled) acc_js.push_back(int'(m_j));
            if (req) req_cyc++;
            if (req && stalled) stall_cyc++;
            if (clear) clear_cyc++;
            if (clear && !stalled) clear_acc_n++;
            if (squash) squash_cyc++;
        end
    end

    task automatic send_cmd(input logic [3:0] p, input logic [5:0] ri, input logic [5:0] n);
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_prob   = p;
        cmd_i      = ri;
        cmd_nverts = n;
        @(negedge clk);
        cmd_valid  = 1'b0;
    endtask

    task automatic wait_row(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (row_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic finish_row();
        @(negedge clk);
        row_ready = 1'b1;
        @(negedge clk);
        row_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_prob = '0; cmd_i = '0; cmd_nverts = '0;
        abort = 1'b0; row_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
        checks++;
        if ({req, clear, squash, row_valid} !== 4'b0) begin
            errors++; $display("FAIL reset_strobes got=%b exp=0000", {req, clear, squash, row_valid});
        end
        checks++;
        if (mask !== 64'h0 || degree !== 7'd0) begin
            errors++; $display("FAIL reset_row mask=%h deg=%0d exp=0/0", mask, degree);
        end
        checks++;
        if ({m_prob, m_i, m_j, m_nverts} !== 22'h0) begin
            errors++; $display("FAIL reset_regs got=%h exp=0", {m_prob, m_i, m_j, m_nverts});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        bit ok; bit bad = 1'b0;
        int a0 = acc_js.size(); int c0 = clear_cyc;
        row_bits = 64'hA5;
        send_cmd(4'd3, 6'd5, 6'd8);
        wait_row(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_timeout row_valid=%b exp=1", row_valid); end
        checks++;
        if (clear_cyc - c0 != 1) begin errors++; $display("FAIL basic_clear got=%0d exp=1", clear_cyc - c0); end
        checks++;
        if (acc_js.size() - a0 != 8) begin errors++; $display("FAIL basic_nreq got=%0d exp=8", acc_js.size() - a0); end
        for (int k = 0; k < 8 && a0 + k < acc_js.size(); k++) if (acc_js[a0 + k] != k) bad = 1'b1;
        checks++;
        if (bad) begin errors++; $display("FAIL basic_jseq got=bad order exp=0..7"); end
        checks++;
        if (mask !== 64'hA5 || degree !== 7'd4) begin
            errors++; $display("FAIL basic_row mask=%h deg=%0d exp=a5/4", mask, degree);
        end
        checks++;
        if (m_prob !== 4'd3 || m_i !== 6'd5 || m_nverts !== 6'd8 || cmd_ready !== 1'b0) begin
            errors++; $display("FAIL basic_regs prob=%0d i=%0d n=%0d rdy=%b exp=3/5/8/0", m_prob, m_i, m_nverts, cmd_ready);
        end
        finish_row();
        checks++;
        if (cmd_ready !== 1'b1 || row_valid !== 1'b0) begin
            errors++; $display("FAIL basic_release rdy=%b rv=%b exp=1/0", cmd_ready, row_valid);
        end
    endtask

    task automatic test_stall();
        bit ok; bit bad = 1'b0;
        int a0 = acc_js.size(); int c0 = clear_cyc; int s0 = stall_cyc;
        row_bits = 64'hA5;
        base_req = req_cyc;
        stall_win = 1'b1;
        send_cmd(4'd3, 6'd6, 6'd8);
        wait_row(ok);
        stall_win = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL stall_timeout row_valid=%b exp=1", row_valid); end
        checks++;
        if (stall_cyc - s0 != 3) begin errors++; $display("FAIL stall_cycles got=%0d exp=3", stall_cyc - s0); end
        checks++;
        if (clear_cyc - c0 != 0) begin errors++; $display("FAIL stall_noclear got=%0d exp=0", clear_cyc - c0); end
        if (acc_js.size() - a0 != 8) bad = 1'b1;
        for (int k = 0; k < 8 && a0 + k < acc_js.size(); k++) if (acc_js[a0 + k] != k) bad = 1'b1;
        checks++;
        if (bad) begin errors++; $display("FAIL stall_jseq got=%0d reqs exp=8 in order", acc_js.size() - a0); end
        checks++;
        if (mask !== 64'hA5 || degree !== 7'd4 || m_i !== 6'd6) begin
            errors++; $display("FAIL stall_row mask=%h deg=%0d i=%0d exp=a5/4/6", mask, degree, m_i);
        end
        finish_row();
    endtask

    task automatic test_zero();
        bit ok;
        int r0 = req_cyc; int c0 = clear_cyc; int ca0 = clear_acc_n;
        row_bits = '1;
        send_cmd(4'd3, 6'd1, 6'd0);
        checks++;
        if (row_valid !== 1'b1 || mask !== 64'h0 || degree !== 7'd0) begin
            errors++; $display("FAIL zero_row rv=%b mask=%h deg=%0d exp=1/0/0", row_valid, mask, degree);
        end
        checks++;
        if (req_cyc != r0 || clear_cyc != c0) begin
            errors++; $display("FAIL zero_noreq reqs=%0d clears=%0d exp=0/0", req_cyc - r0, clear_cyc - c0);
        end
        finish_row();
        base_clr = clear_cyc;
        clr_stall_n = 2;
        send_cmd(4'd7, 6'd1, 6'd0);
        wait_row(ok);
        clr_stall_n = 0;
        checks++;
        if (!ok || clear_cyc - c0 != 3 || clear_acc_n - ca0 != 1) begin
            errors++; $display("FAIL zero_newprob_clear ok=%b cyc=%0d acc=%0d exp=1/3/1", ok, clear_cyc - c0, clear_acc_n - ca0);
        end
        checks++;
        if (mask !== 64'h0 || degree !== 7'd0 || req_cyc != r0) begin
            errors++; $display("FAIL zero_newprob_row mask=%h deg=%0d reqs=%0d exp=0/0/0", mask, degree, req_cyc - r0);
        end
        finish_row();
    endtask

    task automatic test_abort();
        bit ok = 1'b0; bit bad = 1'b0;
        int a0 = acc_js.size(); int q0 = squash_cyc; int ca0;
        row_bits = 64'hFF;
        send_cmd(4'd7, 6'd2, 6'd8);
        for (int c = 0; c < 50; c++) begin
            if (acc_js.size() - a0 >= 3) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL abort_reach3 got=%0d exp=3", acc_js.size() - a0); end
        abort = 1'b1;
        #1;
        checks++;
        if (squash !== 1'b1 || req !== 1'b0) begin
            errors++; $display("FAIL abort_squash sq=%b req=%b exp=1/0", squash, req);
        end
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (cmd_ready !== 1'b1 || squash_cyc - q0 != 1 || acc_js.size() - a0 != 3) begin
            errors++; $display("FAIL abort_idle rdy=%b sq=%0d reqs=%0d exp=1/1/3", cmd_ready, squash_cyc - q0, acc_js.size() - a0);
        end
        for (int c = 0; c < 5; c++) begin
            if (row_valid !== 1'b0 || squash !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin errors++; $display("FAIL abort_norow got=row or squash exp=none"); end
        // abort while the clear is still stalled must leave the known problem as 7
        ca0 = clear_acc_n;
        base_clr = clear_cyc;
        clr_stall_n = 5;
        send_cmd(4'd9, 6'd0, 6'd4);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        clr_stall_n = 0;
        checks++;
        if (cmd_ready !== 1'b1 || clear_acc_n != ca0) begin
            errors++; $display("FAIL abort_clear rdy=%b acc=%0d exp=1/0", cmd_ready, clear_acc_n - ca0);
        end
        ca0 = clear_cyc;
        row_bits = 64'h3C;
        send_cmd(4'd7, 6'd3, 6'd8);
        wait_row(ok);
        checks++;
        if (!ok || clear_cyc != ca0 || mask !== 64'h3C || degree !== 7'd4) begin
            errors++; $display("FAIL abort_next ok=%b clr=%0d mask=%h deg=%0d exp=1/0/3c/4", ok, clear_cyc - ca0, mask, degree);
        end
        finish_row();
    endtask

    task automatic test_backpressure();
        bit ok; bit bad = 1'b0;
        row_bits = 64'h5A5A;
        send_cmd(4'd7, 6'd4, 6'd16);
        wait_row(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_timeout row_valid=%b exp=1", row_valid); end
        for (int c = 0; c < 10; c++) begin
            if (mask !== 64'h5A5A || degree !== 7'd8 || row_valid !== 1'b1 || cmd_ready !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad) begin
            errors++; $display("FAIL bp_hold mask=%h deg=%0d rv=%b rdy=%b exp=5a5a/8/1/0", mask, degree, row_valid, cmd_ready);
        end
        finish_row();
    endtask

    task automatic test_full();
        bit ok; bit bad = 1'b0;
        int a0 = acc_js.size();
        row_bits = '1;
        send_cmd(4'd7, 6'd9, 6'd63);
        wait_row(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL full_timeout row_valid=%b exp=1", row_valid); end
        checks++;
        if (mask !== 64'h7FFF_FFFF_FFFF_FFFF || degree !== 7'd63) begin
            errors++; $display("FAIL full_row mask=%h deg=%0d exp=7fffffffffffffff/63", mask, degree);
        end
        if (acc_js.size() - a0 != 63) bad = 1'b1;
        for (int k = 0; k < 63 && a0 + k < acc_js.size(); k++) if (acc_js[a0 + k] != k) bad = 1'b1;
        checks++;
        if (bad) begin errors++; $display("FAIL full_jseq got=%0d reqs exp=63 in order", acc_js.size() - a0); end
        finish_row();
    endtask

    task automatic test_reset_mid();
        bit ok;
        int c0;
        row_bits = 64'hF0;
        send_cmd(4'd7, 6'd1, 6'd8);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (cmd_ready !== 1'b1 || row_valid !== 1'b0 || req !== 1'b0) begin
            errors++; $display("FAIL midrst_idle rdy=%b rv=%b req=%b exp=1/0/0", cmd_ready, row_valid, req);
        end
        c0 = clear_cyc;
        send_cmd(4'd7, 6'd1, 6'd8);
        wait_row(ok);
        checks++;
        if (!ok || clear_cyc - c0 != 1 || mask !== 64'hF0 || degree !== 7'd4) begin
            errors++; $display("FAIL midrst_row ok=%b clr=%0d mask=%h deg=%0d exp=1/1/f0/4", ok, clear_cyc - c0, mask, degree);
        end
        finish_row();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_zero();
        test_abort();
        test_backpressure();
        test_full();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
